clip_tri_emitter: RTL

Sequencer and output stage for the frustum clipper. It accepts one triangle per handshake from the vertex stage and drives the clipper's level-held start/done protocol. It captures the clipper's 0–2 result triangles and streams them one triangle per beat over valid/ready to rasterizer setup. It also keeps cull and emit statistics.

---
 rtl/clip_tri_emitter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clip_tri_emitter.sv
// clip_tri_emitter: sequences one triangle through the frustum clipper and streams its 0-2 result triangles
module clip_tri_emitter #(
  parameter int WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [12*WIDTH-1:0]   in_tri_i,
  output logic                  clip_start_o,
  output logic [12*WIDTH-1:0]   clip_tri_o,
  input  logic                  clip_done_i,
  input  logic                  clip_valid_i,
  input  logic [1:0]            clip_num_i,
  input  logic [24*WIDTH-1:0]   clip_res_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [12*WIDTH-1:0]   out_tri_o,
  output logic                  out_last_o,
  output logic                  out_split_o,
  output logic                  busy_o,
  output logic [15:0]           culled_cnt_o,
  output logic [15:0]           emitted_cnt_o,
  output logic                  err_o
);
  localparam int TW = 12 * WIDTH;
  typedef enum logic [1:0] {IDLE, START, WAIT, EMIT} state_t;
  state_t state_q, state_d;
  logic clip_start_q, clip_start_d;
  logic [TW-1:0] clip_tri_q, clip_tri_d;
  logic [TW-1:0] res_hi_q, res_hi_d;
  logic [TW-1:0] out_tri_q, out_tri_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic out_split_q, out_split_d;
  logic [15:0] culled_cnt_q, culled_cnt_d;
  logic [15:0] emitted_cnt_q, emitted_cnt_d;
  logic err_q, err_d;
  logic [1:0] n;
  assign in_ready_o    = (state_q == IDLE) && !clip_done_i;
  assign n             = (clip_num_i == 2'd3) ? 2'd2 : clip_num_i;
  assign clip_start_o  = clip_start_q;
  assign clip_tri_o    = clip_tri_q;
  assign out_valid_o   = out_valid_q;
  assign out_tri_o     = out_tri_q;
  assign out_last_o    = out_last_q;
  assign out_split_o   = out_split_q;
  assign busy_o        = state_q != IDLE;
  assign culled_cnt_o  = culled_cnt_q;
  assign emitted_cnt_o = emitted_cnt_q;
  assign err_o         = err_q;
  // Next-state logic; the second result triangle is always the last, so only the first beat needs n
  always_comb begin
    state_d       = state_q;
    clip_start_d  = clip_start_q;
    clip_tri_d    = clip_tri_q;
    res_hi_d      = res_hi_q;
    out_tri_d     = out_tri_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_split_d   = out_split_q;
    culled_cnt_d  = culled_cnt_q;
    emitted_cnt_d = emitted_cnt_q;
    err_d         = err_q;
    unique case (state_q)
      IDLE: if (in_valid_i && in_ready_o) begin
        clip_tri_d   = in_tri_i;
        clip_start_d = 1'b1;
        state_d      = START;
      end
      START: state_d = WAIT;
      WAIT: if (clip_done_i) begin
        clip_start_d = 1'b0;
        res_hi_d     = clip_res_i[2*TW-1:TW];
        err_d        = err_q | (clip_num_i == 2'd3);
        if (!clip_valid_i || n == 2'd0) begin
          culled_cnt_d = culled_cnt_q + 16'd1;
          state_d      = IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_tri_d   = clip_res_i[TW-1:0];
          out_last_d  = n == 2'd1;
          out_split_d = n == 2'd2;
          state_d     = EMIT;
        end
      end
      EMIT: if (out_ready_i) begin
        emitted_cnt_d = emitted_cnt_q + 16'd1;
        out_valid_d   = !out_last_q;
        out_tri_d     = out_last_q ? out_tri_q : res_hi_q;
        out_last_d    = 1'b1;
        state_d       = out_last_q ? IDLE : EMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs; reset discards any buffered result
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      clip_start_q  <= 1'b0;
      clip_tri_q    <= '0;
      res_hi_q      <= '0;
      out_tri_q     <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_split_q   <= 1'b0;
      culled_cnt_q  <= '0;
      emitted_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      clip_start_q  <= clip_start_d;
      clip_tri_q    <= clip_tri_d;
      res_hi_q      <= res_hi_d;
      out_tri_q     <= out_tri_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_split_q   <= out_split_d;
      culled_cnt_q  <= culled_cnt_d;
      emitted_cnt_q <= emitted_cnt_d;
      err_q         <= err_d;
    end
  end
endmodule
